imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised RV32I/RV64I immediate generator for the decode stage: covers all base formats
//  (I/S/B/U/J, incl. JALR/LUI/AUIPC/JAL), with the fetch->decode handshake registered.
//  Sits between the fetch instruction register and the operand/ALU mux.
//  Output register plus skid buffer, so both valid/ready sides are fully registered.
//  Adds format tag, illegal-opcode flag and saturating illegal counter.
// PARAMETERS
//  XLEN    32  immediate width; legal 32 or 64; sign extension fills bits XLEN-1..31
//  CNT_W   16  width of illegal-opcode counter
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      fetch presents in_instr
//  in_ready     out  1      block can accept this cycle
//  in_instr     in   32     raw instruction word
//  out_valid    out  1      out_* fields valid
//  out_ready    in   1      decode consumer accepts
//  out_instr    out  32     instruction passthrough, aligned with out_imm
//  out_imm      out  XLEN   sign-extended immediate
//  out_fmt      out  3      0=R 1=I 2=S 3=B 4=U 5=J 7=none
//  out_illegal  out  1      opcode not in supported set
//  illegal_cnt  out  CNT_W  count of accepted illegal instructions, saturates at all-ones
// BEHAVIOUR
//  Opcode map:
//   - 0110011 -> R, imm=0
//   - 0010011, 0000011, 1100111 -> I
//   - 0100011 -> S;  1100011 -> B;  0110111, 0010111 -> U;  1101111 -> J
//   - other -> fmt=7, imm=0, illegal=1
//  Immediates (s = instr[31], replicated to XLEN):
//   - I = s..,i[31:20]
//   - S = s..,i[31:25],i[11:7]
//   - B = s..,i[31],i[7],i[30:25],i[11:8],0
//   - U = s..,i[31:12],12'b0
//   - J = s..,i[31],i[19:12],i[20],i[30:21],0
//  Handshakes:
//   - Transfer occurs when valid&&ready on a side.
//   - Latency: accepted word appears on out_* the next cycle.
//   - Throughput: 1/cycle while out_ready=1.
//  Pipeline states:
//   - EMPTY: out_valid=0, in_ready=1.
//   - ONE: main reg valid, in_ready=1.
//   - FULL: main and skid valid, in_ready=0.
//  Transitions:
//   - EMPTY + accept -> ONE.
//   - ONE + accept & !out_ready -> FULL; word goes to skid.
//   - ONE + accept & out_ready -> ONE; main reloads.
//   - ONE + !accept & out_ready -> EMPTY.
//   - FULL + out_ready -> ONE; skid moves to main.
//  Output stability: out_* held stable while out_valid && !out_ready.
//  in_ready is a register output; no combinational in->out path.
//  illegal_cnt:
//   - Increments once per accepted illegal word, at acceptance.
//   - Holds at 2^CNT_W-1.
//  Reset (rst=1 at an edge):
//   - out_valid=0, out_imm=0, out_instr=0, out_fmt=7, out_illegal=0, illegal_cnt=0.
//   - State EMPTY, skid cleared.
//   - in_ready=0 while rst is high, 1 on the first cycle after.
//  Reset mid-operation: in-flight and skid words are discarded, no partial output.
//  A word presented while rst=1 is not accepted.
// TESTING
//  1. beq x0,x0,-4 (0xFE000EE3), out_ready=1:
//     next cycle out_imm=0xFFFFFFFC, fmt=3.
//  2. lui x1,0x12345 (0x123450B7):
//     XLEN=32 -> out_imm=0x12345000, fmt=4.
//     XLEN=64 with 0x800000B7 -> out_imm=0xFFFFFFFF80000000.
//  3. Back-to-back immediates:
//     jal x1,2048 (0x001000EF) -> out_imm=0x00000800, fmt=5.
//     sw x2,-1(x1) (0xFE20AFA3) -> out_imm=0xFFFFFFFF, fmt=2.
//  4. Backpressure: hold out_ready=0 and push 3 words.
//     Required: 2 accepted, in_ready=0 on the 3rd, out_* stable.
//     Then release: words appear in order with no loss or duplication.
//  5. Illegal opcode 0x0000007F:
//     out_illegal=1, fmt=7, imm=0, illegal_cnt 0->1.
//     With CNT_W=2, 5 illegal words -> cnt saturates at 3.
//  6. rst pulsed while state is FULL:
//     next cycle out_valid=0, cnt=0, in_ready=0.
//     Cycle after rst drops, in_ready=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with a registered valid/ready pipeline.
// Each accepted word is decoded into an immediate, format tag and illegal flag.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } word_t;

  localparam word_t WORD_RST = '{instr: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_e             state, state_nxt;
  word_t              main_q, skid_q, dec;
  logic signed [31:0] imm32;
  logic               sign;
  logic               in_ready_q;
  logic               accept;
  logic               load_main_in, load_main_skid, load_skid;

  assign accept = in_valid && in_ready_q;
  assign sign   = in_instr[31];

  // Decode happens on the input side so both main and skid hold finished words.
  // NOTE: every always_comb output gets a default first, otherwise a missed case branch infers a latch.
  always_comb begin
    imm32       = '0;
    dec.instr   = in_instr;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      OP_R: dec.fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        imm32   = {{20{sign}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{sign}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{sign}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{sign}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    // Signed size cast fills bits XLEN-1..32 with bit 31 on RV64.
    dec.imm = XLEN'(imm32);
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  // NOTE: the data registers are reset on purpose: the outputs must show defined values after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q      <= WORD_RST;
      skid_q      <= WORD_RST;
      illegal_cnt <= '0;
    end else begin
      if (load_main_in)        main_q <= dec;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec;
      if (accept && dec.illegal && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state != EMPTY);
  assign out_instr   = main_q.instr;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 and RV64/2-bit-counter instances share one stimulus
// stream and are compared every cycle against a queue-based behavioural model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_instr_a, out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [15:0] illegal_cnt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] out_instr_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [1:0]  illegal_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
    .illegal_cnt(illegal_cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
    .illegal_cnt(illegal_cnt_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  function automatic exp_t model_word(input logic [31:0] i);
    exp_t   e;
    longint s;
    s         = longint'($signed(i));
    e.instr   = i;
    e.imm     = 64'd0;
    e.fmt     = 3'd7;
    e.illegal = 1'b0;
    case (i[6:0])
      7'b0110011: e.fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e.fmt = 3'd1;
        e.imm = s >>> 20;
      end
      7'b0100011: begin
        e.fmt = 3'd2;
        e.imm = (s >>> 25) * 32 + longint'(i[11:7]);
      end
      7'b1100011: begin
        e.fmt = 3'd3;
        e.imm = (s >>> 31) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
              + longint'(i[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4;
        e.imm = s - longint'(i[11:0]);
      end
      7'b1101111: begin
        e.fmt = 3'd5;
        e.imm = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
              + longint'(i[30:21]) * 2;
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  exp_t q[$];
  bit   m_ready     = 1'b0;
  bit   m_after_rst = 1'b0;
  bit   m_init      = 1'b0;
  int   m_cnt       = 0;

  // Model holds up to two words in flight; ready is known one edge ahead.
  always @(posedge clk) begin
    bit   acc;
    exp_t e;
    if (rst) begin
      q.delete();
      m_ready     = 1'b0;
      m_cnt       = 0;
      m_after_rst = 1'b1;
      m_init      = 1'b1;
    end else if (m_init) begin
      m_after_rst = 1'b0;
      acc = in_valid && m_ready;
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        e = model_word(in_instr);
        q.push_back(e);
        if (e.illegal) m_cnt++;
      end
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready_a", in_ready_a, m_ready);
      check("in_ready_b", in_ready_b, m_ready);
      check("out_valid_a", out_valid_a, q.size() > 0);
      check("out_valid_b", out_valid_b, q.size() > 0);
      check("illegal_cnt_a", illegal_cnt_a, (m_cnt > 65535) ? 65535 : m_cnt);
      check("illegal_cnt_b", illegal_cnt_b, (m_cnt > 3) ? 3 : m_cnt);
      if (m_after_rst) begin
        check("rst_instr", out_instr_a, 0);
        check("rst_imm_a", out_imm_a, 0);
        check("rst_imm_b", out_imm_b, 0);
        check("rst_fmt", out_fmt_a, 7);
        check("rst_illegal", out_illegal_a, 0);
      end
      if (q.size() > 0) begin
        check("instr_a", out_instr_a, q[0].instr);
        check("instr_b", out_instr_b, q[0].instr);
        check("imm_a", out_imm_a, {32'd0, q[0].imm[31:0]});
        check("imm_b", out_imm_b, q[0].imm);
        check("fmt_a", out_fmt_a, q[0].fmt);
        check("fmt_b", out_fmt_b, q[0].fmt);
        check("illegal_a", out_illegal_a, q[0].illegal);
        check("illegal_b", out_illegal_b, q[0].illegal);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs, take one rising edge, return 1 time unit after it.
  task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic ordy);
    rst       = r;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 32'h0000_0013, 1'b1);
    check("ready_low_in_rst", in_ready_a, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("ready_after_rst", in_ready_a, 1);
    check("valid_after_rst", out_valid_a, 0);

    // Branch, LUI, RV64 sign fill, back-to-back JAL/SW.
    step(1'b0, 1'b1, 32'hFE00_0EE3, 1'b1);
    check("beq_imm", out_imm_a, 64'hFFFF_FFFC);
    check("beq_fmt", out_fmt_a, 3);
    check("beq_imm64", out_imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b1, 32'h1234_50B7, 1'b1);
    check("lui_imm", out_imm_a, 64'h1234_5000);
    check("lui_fmt", out_fmt_a, 4);
    step(1'b0, 1'b1, 32'h8000_00B7, 1'b1);
    check("lui_imm64", out_imm_b, 64'hFFFF_FFFF_8000_0000);
    step(1'b0, 1'b1, 32'h0010_00EF, 1'b1);
    check("jal_imm", out_imm_a, 64'h0000_0800);
    check("jal_fmt", out_fmt_a, 5);
    step(1'b0, 1'b1, 32'hFE20_AFA3, 1'b1);
    check("sw_imm", out_imm_a, 64'hFFFF_FFFF);
    check("sw_fmt", out_fmt_a, 2);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("drained", out_valid_a, 0);

    // Backpressure: three pushes, two land, outputs frozen, then in-order drain.
    step(1'b0, 1'b1, 32'h0010_0093, 1'b0);
    check("bp_ready1", in_ready_a, 1);
    step(1'b0, 1'b1, 32'h0020_0113, 1'b0);
    check("bp_ready2", in_ready_a, 0);
    check("bp_hold1", out_instr_a, 32'h0010_0093);
    step(1'b0, 1'b1, 32'h0030_0193, 1'b0);
    check("bp_ready3", in_ready_a, 0);
    check("bp_hold2", out_instr_a, 32'h0010_0093);
    check("bp_imm", out_imm_a, 64'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_second", out_instr_a, 32'h0020_0113);
    check("bp_ready_rel", in_ready_a, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_empty", out_valid_a, 0);

    // Illegal opcode and counter saturation on the 2-bit instance.
    check("cnt_before", illegal_cnt_a, 0);
    step(1'b0, 1'b1, 32'h0000_007F, 1'b1);
    check("ill_flag", out_illegal_a, 1);
    check("ill_fmt", out_fmt_a, 7);
    check("ill_imm", out_imm_a, 0);
    check("ill_cnt1", illegal_cnt_a, 1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h0000_007F, 1'b1);
    check("ill_cnt5", illegal_cnt_a, 5);
    check("ill_sat", illegal_cnt_b, 3);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while FULL.
    step(1'b0, 1'b1, 32'h0000_0513, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0593, 1'b0);
    check("full_ready", in_ready_a, 0);
    step(1'b1, 1'b1, 32'h0000_0613, 1'b0);
    check("mid_rst_valid", out_valid_a, 0);
    check("mid_rst_cnt", illegal_cnt_a, 0);
    check("mid_rst_ready", in_ready_a, 0);
    step(1'b0, 1'b1, 32'h0000_0693, 1'b1);
    check("post_rst_ready", in_ready_a, 1);
    check("post_rst_valid", out_valid_a, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), w,
           ($urandom_range(0, 2) != 0));
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
